sram_like_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the load/store requester (data_*).
- Sits between the CPU core (IF stage inst_sram_* and MEM stage data_sram_*) and the single SRAM-like-to-AXI bridge.
- Arbitrates address phases and tracks outstanding transactions in order, so each data_ok/rdata returns to the requester that issued it.

---
 rtl/sram_like_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares one SRAM-like memory port between the instruction-fetch (inst_*) and
// load/store (data_*) requesters. Address phases are arbitrated and passed
// through combinationally. Accepted transactions are logged in an in-order
// owner FIFO, so each data_ok/rdata is routed back to the requester that
// issued it.
// Optional feature: define SRAM_ARB_RR_EN to break inst/data ties
// round-robin instead of with fixed DATA-over-INST priority.
module sram_like_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int OT_AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    // instruction-fetch requester
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared port towards the bridge
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_e;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    localparam logic [OT_AW:0]   DEPTH_C = (OT_AW+1)'(OT_DEPTH);
    localparam logic [OT_AW:0]   CNT_ONE = (OT_AW+1)'(1);
    localparam logic [OT_AW-1:0] PTR_ONE = OT_AW'(1);

    // Owner FIFO: one bit per outstanding transaction, 1 = DATA, 0 = INST.
    logic [OT_DEPTH-1:0] owner_q, owner_d;
    logic [OT_AW-1:0]    wptr_q, wptr_d;
    logic [OT_AW-1:0]    rptr_q, rptr_d;
    logic [OT_AW:0]      count_q, count_d;
    // Lock pins the grant to a requester whose address phase is stalled.
    logic                lock_valid_q, lock_valid_d;
    logic                lock_owner_q, lock_owner_d;

    sram_req_t inst_r, data_r, mem_r;
    grant_e    grant;
    logic      full;
    logic      accept;
    logic      pop;
    logic      head_owner;

    assign inst_r = {inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_r = {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata};

    assign full = (count_q == DEPTH_C);

`ifdef SRAM_ARB_RR_EN
    // Last accepted requester (1 = DATA); a tie goes to the other one.
    logic rr_last_q, rr_last_d;

    // Remember who won the most recent accepted address phase.
    always_comb begin
        rr_last_d = rr_last_q;
        if (accept) rr_last_d = (grant == GNT_DATA);
    end

    // Round-robin state register; resets to INST so DATA wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_last_q <= 1'b0;
        else       rr_last_q <= rr_last_d;
    end
`endif

    // Grant selection: nothing while full or in reset, lock holder next,
    // then the tie-break between simultaneous requests.
    always_comb begin
        grant = GNT_NONE;
        if (reset || full) begin
            grant = GNT_NONE;
        end else if (lock_valid_q) begin
            grant = lock_owner_q ? GNT_DATA : GNT_INST;
        end else if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
            grant = rr_last_q ? GNT_INST : GNT_DATA;
`else
            grant = GNT_DATA;
`endif
        end else if (data_req) begin
            grant = GNT_DATA;
        end else if (inst_req) begin
            grant = GNT_INST;
        end
    end

    // Request mux: the granted requester's fields, zero when nobody holds the grant.
    always_comb begin
        mem_r = '0;
        case (grant)
            GNT_INST: mem_r = inst_r;
            GNT_DATA: mem_r = data_r;
            default:  mem_r = '0;
        endcase
    end

    assign mem_req   = mem_r.req;
    assign mem_wr    = mem_r.wr;
    assign mem_size  = mem_r.size;
    assign mem_wstrb = mem_r.wstrb;
    assign mem_addr  = mem_r.addr;
    assign mem_wdata = mem_r.wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (grant == GNT_INST);
    assign data_addr_ok = accept & (grant == GNT_DATA);

    // A data_ok with nothing outstanding is spurious and is dropped here.
    assign pop          = mem_data_ok & (count_q != '0) & ~reset;
    assign head_owner   = owner_q[rptr_q];
    assign inst_data_ok = pop & ~head_owner;
    assign data_data_ok = pop &  head_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Next state for the owner FIFO and the address-phase lock.
    always_comb begin
        owner_d      = owner_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;

        if (accept) begin
            owner_d[wptr_q] = (grant == GNT_DATA);
            wptr_d          = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (mem_req && !mem_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_owner_d = (grant == GNT_DATA);
        end else if (accept) begin
            lock_valid_d = 1'b0;
        end
    end

    // State registers; reset abandons anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios followed by random traffic, checked
// against a queue-based reference model of the arbiter's rules.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OT_DEPTH(DEPTH), .OT_AW(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of owners (1 = DATA) in acceptance order.
    bit oq[$];
    bit m_lock_v, m_lock_o, m_rr;
    bit acc_i, acc_d;
    int g;        // 0 none, 1 inst, 2 data
    bit e_req, e_pop;

    function automatic int mgrant();
        if (reset) return 0;
        if (oq.size() == DEPTH) return 0;
        if (m_lock_v) return m_lock_o ? 2 : 1;
        if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
            return m_rr ? 1 : 2;
`else
            return 2;
`endif
        end
        if (data_req) return 2;
        if (inst_req) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model on the falling edge.
    task automatic sample();
        logic [31:0] ea, ew;
        logic [1:0]  es;
        logic [3:0]  eb;
        logic        ewr;
        bit          head;
        @(negedge clk);
        g     = mgrant();
        e_req = (g == 2) ? data_req : (g == 1) ? inst_req : 1'b0;
        ea  = (g == 2) ? data_addr  : (g == 1) ? inst_addr  : 32'h0;
        ew  = (g == 2) ? data_wdata : (g == 1) ? inst_wdata : 32'h0;
        es  = (g == 2) ? data_size  : (g == 1) ? inst_size  : 2'h0;
        eb  = (g == 2) ? data_wstrb : (g == 1) ? inst_wstrb : 4'h0;
        ewr = (g == 2) ? data_wr    : (g == 1) ? inst_wr    : 1'b0;
        e_pop = mem_data_ok && (oq.size() != 0) && !reset;
        head  = e_pop ? oq[0] : 1'b0;
        chk("mem_req", mem_req, e_req);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_size", mem_size, es);
        chk("mem_wstrb", mem_wstrb, eb);
        chk("mem_wr", mem_wr, ewr);
        chk("inst_addr_ok", inst_addr_ok, mem_addr_ok & e_req & (g == 1));
        chk("data_addr_ok", data_addr_ok, mem_addr_ok & e_req & (g == 2));
        chk("inst_data_ok", inst_data_ok, e_pop & !head);
        chk("data_data_ok", data_data_ok, e_pop & head);
        if (e_pop && !head) chk("inst_rdata", inst_rdata, mem_rdata);
        if (e_pop && head)  chk("data_rdata", data_rdata, mem_rdata);
    endtask

    // Advance the model across the rising edge using the sampled decision.
    task automatic adv();
        bit acc;
        @(posedge clk);
        acc_i = 0;
        acc_d = 0;
        if (reset) begin
            oq.delete();
            m_lock_v = 0;
            m_lock_o = 0;
            m_rr     = 0;
        end else begin
            acc   = e_req && mem_addr_ok;
            acc_i = acc && (g == 1);
            acc_d = acc && (g == 2);
            if (e_pop) void'(oq.pop_front());
            if (acc) oq.push_back(g == 2);
            if (e_req && !mem_addr_ok) begin
                m_lock_v = 1;
                m_lock_o = (g == 2);
            end else if (acc) begin
                m_lock_v = 0;
            end
            if (acc) m_rr = (g == 2);
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic set_i(input bit r, input logic [31:0] a);
        inst_req   = r;
        inst_addr  = a;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_wstrb = 4'hf;
        inst_wdata = $urandom;
    endtask

    task automatic set_d(input bit r, input logic [31:0] a);
        data_req   = r;
        data_addr  = a;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_wdata = $urandom;
    endtask

    task automatic idle();
        inst_req    = 0;
        data_req    = 0;
        mem_addr_ok = 0;
        mem_data_ok = 0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < DEPTH + 1 && oq.size() > 0; k++) begin
            mem_data_ok = 1;
            mem_rdata   = $urandom;
            cyc();
        end
        mem_data_ok = 0;
    endtask

    initial begin
        // Reset state: handshakes stay low even with everything asserted.
        reset = 1;
        set_i(1, 32'h1000);
        set_d(1, 32'h2000);
        mem_addr_ok = 1;
        mem_data_ok = 1;
        mem_rdata   = 32'h0;
        sample();
        chk("rst_mem_req", mem_req, 1'b0);
        adv();
        reset = 0;
        idle();

        // Single fetch.
        set_i(1, 32'hbfc00000);
        mem_addr_ok = 1;
        sample();
        chk("fetch_addr_ok", inst_addr_ok, 1'b1);
        chk("fetch_mem_addr", mem_addr, 32'hbfc00000);
        adv();
        idle();
        cyc();
        cyc();
        mem_data_ok = 1;
        mem_rdata   = 32'h3c1d8000;
        sample();
        chk("fetch_data_ok", inst_data_ok, 1'b1);
        chk("fetch_rdata", inst_rdata, 32'h3c1d8000);
        chk("fetch_no_ddok", data_data_ok, 1'b0);
        adv();
        idle();

        // Contention: DATA wins the first tie, INST next cycle.
        set_i(1, 32'h00400000);
        set_d(1, 32'h80001000);
        mem_addr_ok = 1;
        sample();
        chk("cont_mem_addr", mem_addr, 32'h80001000);
        chk("cont_daok", data_addr_ok, 1'b1);
        chk("cont_iaok0", inst_addr_ok, 1'b0);
        adv();
        set_d(0, 32'h0);
        sample();
        chk("cont_iaok1", inst_addr_ok, 1'b1);
        adv();
        drain();
        // Repeated tie: alternates with round-robin, DATA-only otherwise.
        set_i(1, 32'h00400010);
        set_d(1, 32'h80001010);
        mem_addr_ok = 1;
        repeat (4) cyc();
        drain();

        // Lock: a stalled INST request keeps the grant after DATA arrives.
        set_i(1, 32'hbfc00100);
        cyc();
        cyc();
        set_d(1, 32'h80002000);
        sample();
        chk("lock_addr", mem_addr, 32'hbfc00100);
        chk("lock_no_daok", data_addr_ok, 1'b0);
        adv();
        mem_addr_ok = 1;
        sample();
        chk("lock_iaok", inst_addr_ok, 1'b1);
        adv();
        set_i(0, 32'h0);
        sample();
        chk("lock_daok_after", data_addr_ok, 1'b1);
        adv();
        drain();

        // Full: four outstanding blocks further requests until a pop.
        set_d(1, 32'h80003000);
        mem_addr_ok = 1;
        repeat (4) cyc();
        set_i(1, 32'h00400020);
        sample();
        chk("full_mem_req", mem_req, 1'b0);
        chk("full_iaok", inst_addr_ok, 1'b0);
        chk("full_daok", data_addr_ok, 1'b0);
        adv();
        mem_data_ok = 1;
        mem_rdata   = 32'h55;
        cyc();
        mem_data_ok = 0;
        sample();
        chk("full_after_pop", mem_req, 1'b1);
        adv();
        drain();

        // Ordering: I,D,I,D returns 1,3 to inst and 2,4 to data.
        mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            set_i(k % 2 == 0, 32'h00500000 + 32'(k));
            set_d(k % 2 == 1, 32'h80005000 + 32'(k));
            cyc();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            mem_data_ok = 1;
            mem_rdata   = 32'(k + 1);
            sample();
            if (k % 2 == 0) begin
                chk("ord_iok", inst_data_ok, 1'b1);
                chk("ord_irdata", inst_rdata, 32'(k + 1));
            end else begin
                chk("ord_dok", data_data_ok, 1'b1);
                chk("ord_drdata", data_rdata, 32'(k + 1));
            end
            adv();
        end
        sample();
        chk("spur_iok", inst_data_ok, 1'b0);
        chk("spur_dok", data_data_ok, 1'b0);
        adv();
        idle();

        // Reset with two outstanding: outputs drop at once, later data ignored.
        set_i(1, 32'h00600000);
        mem_addr_ok = 1;
        cyc();
        set_i(0, 32'h0);
        set_d(1, 32'h80006000);
        cyc();
        reset       = 1;
        mem_data_ok = 1;
        #1;
        chk("mrst_mem_req", mem_req, 1'b0);
        chk("mrst_daok", data_addr_ok, 1'b0);
        chk("mrst_ddok", data_data_ok, 1'b0);
        sample();
        adv();
        reset = 0;
        idle();
        mem_data_ok = 1;
        sample();
        chk("mrst_late_iok", inst_data_ok, 1'b0);
        chk("mrst_late_dok", data_data_ok, 1'b0);
        adv();
        idle();

        // Random traffic obeying the hold-until-addr_ok protocol.
        for (int n = 0; n < 600; n++) begin
            if (acc_i) inst_req = 0;
            if (acc_d) data_req = 0;
            if (!inst_req && $urandom_range(0, 2) == 0) set_i(1, $urandom);
            if (!data_req && $urandom_range(0, 2) == 0) set_d(1, $urandom);
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom;
            cyc();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
